// File: rtl/arb_mux_pkg.sv
// arb_mux shared definitions.
// Mode encodings used by the arbitrating multiplexer.
package arb_mux_pkg;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'b00,
        ARB_RR    = 2'b01,
        ARB_FORCE = 2'b10,
        ARB_RSVD  = 2'b11
    } arb_mode_e;

endpackage

// File: rtl/arb_mux_pick.sv
// arb_pick: combinational grant selection.
// Rotating priority search or forced index.
module arb_pick
    import arb_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] start,
    input  logic          force_en,
    input  logic [SW-1:0] force_idx,
    output logic [N-1:0]  gnt_onehot,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    int w_c;

    // First valid at/after start (wrapping), or the forced channel only.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_c        = 0;
        if (force_en) begin
            for (int i = 0; i < N; i++) begin
                if (force_idx == SW'(i) && valid[i]) begin
                    gnt_onehot[i] = 1'b1;
                    gnt_idx       = SW'(i);
                    any           = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                w_c = int'(start) + k;
                if (w_c >= N) begin
                    w_c = w_c - N;
                end
                if (!any && valid[w_c]) begin
                    gnt_onehot[w_c] = 1'b1;
                    gnt_idx         = SW'(w_c);
                    any             = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel registered arbitrating multiplexer.
// Valid/ready on each input and on the single output.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [SW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_sel
);

    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_sel;
    logic             r_valid;
    logic [SW-1:0]    r_ptr;

    arb_mode_e        w_mode;
    logic             w_load;
    logic             w_rr;
    logic             w_force;
    logic [SW-1:0]    w_start;
    logic [N-1:0]     w_onehot;
    logic [SW-1:0]    w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_gdata;

    assign w_mode  = arb_mode_e'(mode);
    assign w_rr    = (w_mode == ARB_RR);
    assign w_force = (w_mode == ARB_FORCE);
    assign w_start = w_rr ? r_ptr : '0;
    assign w_load  = ~r_valid | out_ready;

    arb_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .valid      (in_valid),
        .start      (w_start),
        .force_en   (w_force),
        .force_idx  (sel),
        .gnt_onehot (w_onehot),
        .gnt_idx    (w_idx),
        .any        (w_any)
    );

    assign in_ready = w_onehot & {N{w_load & ~reset}};

    // Route the granted channel's data to the output register input.
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_onehot[i]) begin
                w_gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; drain and refill share an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_data  <= w_gdata;
                r_sel   <= w_idx;
                r_valid <= 1'b1;
                if (w_rr) begin
                    r_ptr <= (w_idx == SW'(N-1)) ? '0 : w_idx + SW'(1);
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;

endmodule
